// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one RAM and the GPIO block between two cores.
// One registered bus transaction at a time: IDLE -> ISSUE (strobe) -> COMPLETE (data/ack).
module dual_core_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int GPIO_SEL_BIT = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread0,
    input  logic              memwrite0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] writedata0,
    output logic [DATA_W-1:0] memdata0,
    output logic              stall0,
    input  logic              memread1,
    input  logic              memwrite1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] writedata1,
    output logic [DATA_W-1:0] memdata1,
    output logic              stall1,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] writedata,
    output logic              memread_ram,
    output logic              memwrite_ram,
    output logic              memread_gpio,
    output logic              memwrite_gpio,
    input  logic [DATA_W-1:0] memdata_ram,
    input  logic [DATA_W-1:0] memdata_gpio,
    output logic              gnt_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                gnt_q, gnt_d;
    logic                last_gnt_q, last_gnt_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    // {wr_gpio, rd_gpio, wr_ram, rd_ram}
    logic [3:0]          strb_q, strb_d;

    logic                req0_s, req1_s;
    logic                capture_s, cap_id_s;
    logic [ADDR_W-1:0]   cap_addr_s;
    logic [DATA_W-1:0]   cap_wdata_s;
    logic                cap_wr_s;
    logic                cap_gpio_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                done0_s, done1_s;

    // Arbitration, next-state and capture logic.
    always_comb begin
        req0_s     = memread0 | memwrite0;
        req1_s     = memread1 | memwrite1;
        sel_data_s = addr_q[GPIO_SEL_BIT] ? memdata_gpio : memdata_ram;

        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        capture_s  = 1'b0;
        cap_id_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_s | req1_s) begin
                    capture_s = 1'b1;
                    if (req0_s & req1_s) begin
                        cap_id_s = ~last_gnt_q;
                    end else begin
                        cap_id_s = req1_s;
                    end
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_COMPLETE;
            end
            S_COMPLETE: begin
                if (!wr_q) begin
                    if (gnt_q) begin
                        rdata1_d = sel_data_s;
                    end else begin
                        rdata0_d = sel_data_s;
                    end
                end else begin
                    rdata0_d = rdata0_q;
                end
                // Only the other core may be captured here; the finishing core re-arbitrates from IDLE.
                if (gnt_q ? req0_s : req1_s) begin
                    capture_s = 1'b1;
                    cap_id_s  = ~gnt_q;
                    state_d   = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cap_addr_s  = cap_id_s ? addr1 : addr0;
        cap_wdata_s = cap_id_s ? writedata1 : writedata0;
        cap_wr_s    = cap_id_s ? memwrite1 : memwrite0;
        cap_gpio_s  = cap_addr_s[GPIO_SEL_BIT];

        if (capture_s) begin
            addr_d     = cap_addr_s;
            wdata_d    = cap_wdata_s;
            wr_d       = cap_wr_s;
            gnt_d      = cap_id_s;
            last_gnt_d = cap_id_s;
            strb_d     = {cap_gpio_s & cap_wr_s, cap_gpio_s & ~cap_wr_s,
                          ~cap_gpio_s & cap_wr_s, ~cap_gpio_s & ~cap_wr_s};
        end else begin
            strb_d     = 4'b0000;
        end
    end

    // Core-facing stall and read-data steering.
    always_comb begin
        done0_s  = (state_q == S_COMPLETE) & ~gnt_q;
        done1_s  = (state_q == S_COMPLETE) & gnt_q;
        stall0   = req0_s & ~done0_s;
        stall1   = req1_s & ~done1_s;
        memdata0 = (done0_s & ~wr_q) ? sel_data_s : rdata0_q;
        memdata1 = (done1_s & ~wr_q) ? sel_data_s : rdata1_q;
    end

    // All arbiter state; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            wr_q       <= 1'b0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            rdata0_q   <= {DATA_W{1'b0}};
            rdata1_q   <= {DATA_W{1'b0}};
            strb_q     <= 4'b0000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            strb_q     <= strb_d;
        end
    end

    assign addr          = addr_q;
    assign writedata     = wdata_q;
    assign memread_ram   = strb_q[0];
    assign memwrite_ram  = strb_q[1];
    assign memread_gpio  = strb_q[2];
    assign memwrite_gpio = strb_q[3];
    assign gnt_id        = gnt_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Directed bench for dual_core_mem_arbiter with hand-computed expectations.
module tb_dual_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread0, memwrite0, memread1, memwrite1;
    logic [15:0] addr0, addr1, addr;
    logic [7:0]  writedata0, writedata1, writedata;
    logic [7:0]  memdata0, memdata1, memdata_ram, memdata_gpio;
    logic        stall0, stall1;
    logic        memread_ram, memwrite_ram, memread_gpio, memwrite_gpio;
    logic        gnt_id, busy;

    int passed = 0;
    int total  = 0;

    dual_core_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .memread0(memread0), .memwrite0(memwrite0), .addr0(addr0),
        .writedata0(writedata0), .memdata0(memdata0), .stall0(stall0),
        .memread1(memread1), .memwrite1(memwrite1), .addr1(addr1),
        .writedata1(writedata1), .memdata1(memdata1), .stall1(stall1),
        .addr(addr), .writedata(writedata),
        .memread_ram(memread_ram), .memwrite_ram(memwrite_ram),
        .memread_gpio(memread_gpio), .memwrite_gpio(memwrite_gpio),
        .memdata_ram(memdata_ram), .memdata_gpio(memdata_gpio),
        .gnt_id(gnt_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        memread0 = 1'b0; memwrite0 = 1'b0; addr0 = 16'h0000; writedata0 = 8'h00;
        memread1 = 1'b0; memwrite1 = 1'b0; addr1 = 16'h0000; writedata1 = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    int run0, run1, max_run, completions;

    initial begin
        idle_inputs();
        memdata_ram  = 8'h00;
        memdata_gpio = 8'h00;
        reset        = 1'b0;
        memread0     = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst_addr", addr, 16'h0000);
        chk("rst_wdata", writedata, 8'h00);
        chk("rst_strobes", {memread_ram, memwrite_ram, memread_gpio, memwrite_gpio}, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", gnt_id, 1'b0);
        chk("rst_md0", memdata0, 8'h00);
        chk("rst_md1", memdata1, 8'h00);
        chk("rst_stall0", stall0, 1'b1);
        chk("rst_stall1", stall1, 1'b0);
        memread0 = 1'b0;
        reset    = 1'b1;
        tick();

        // 1: core0 RAM read
        memread0 = 1'b1; addr0 = 16'h0010; memdata_ram = 8'hA5;
        settle();
        chk("t1_c0_stall0", stall0, 1'b1);
        chk("t1_c0_rd_ram", memread_ram, 1'b0);
        tick();
        chk("t1_c1_rd_ram", memread_ram, 1'b1);
        chk("t1_c1_addr", addr, 16'h0010);
        chk("t1_c1_busy", busy, 1'b1);
        chk("t1_c1_stall0", stall0, 1'b1);
        chk("t1_c1_others", {memwrite_ram, memread_gpio, memwrite_gpio}, 3'b000);
        tick();
        chk("t1_c2_rd_ram", memread_ram, 1'b0);
        chk("t1_c2_stall0", stall0, 1'b0);
        chk("t1_c2_md0", memdata0, 8'hA5);
        tick();
        memread0 = 1'b0; memdata_ram = 8'h00;
        settle();
        chk("t1_hold_md0", memdata0, 8'hA5);
        chk("t1_idle_busy", busy, 1'b0);
        tick();

        // 2: core1 GPIO write
        memwrite1 = 1'b1; addr1 = 16'h0200; writedata1 = 8'h3C;
        tick();
        chk("t2_c1_wr_gpio", memwrite_gpio, 1'b1);
        chk("t2_c1_addr", addr, 16'h0200);
        chk("t2_c1_wdata", writedata, 8'h3C);
        chk("t2_c1_ram", {memread_ram, memwrite_ram}, 2'b00);
        chk("t2_c1_gnt", gnt_id, 1'b1);
        chk("t2_c1_stall1", stall1, 1'b1);
        tick();
        chk("t2_c2_stall1", stall1, 1'b0);
        chk("t2_c2_wr_gpio", memwrite_gpio, 1'b0);
        tick();
        idle_inputs();
        tick();

        // 3: simultaneous reads right after reset
        do_reset();
        memread0 = 1'b1; addr0 = 16'h0010;
        memread1 = 1'b1; addr1 = 16'h0201;
        memdata_ram = 8'hA5; memdata_gpio = 8'h77;
        tick();
        chk("t3_c1_gnt", gnt_id, 1'b0);
        chk("t3_c1_rd_ram", memread_ram, 1'b1);
        chk("t3_c1_stall1", stall1, 1'b1);
        tick();
        chk("t3_c2_stall0", stall0, 1'b0);
        chk("t3_c2_stall1", stall1, 1'b1);
        chk("t3_c2_md0", memdata0, 8'hA5);
        tick();
        memread0 = 1'b0;
        settle();
        chk("t3_c3_gnt", gnt_id, 1'b1);
        chk("t3_c3_rd_gpio", memread_gpio, 1'b1);
        chk("t3_c3_addr", addr, 16'h0201);
        chk("t3_c3_stall1", stall1, 1'b1);
        tick();
        chk("t3_c4_stall1", stall1, 1'b0);
        chk("t3_c4_md1", memdata1, 8'h77);
        tick();
        idle_inputs();
        settle();
        chk("t3_hold_md0", memdata0, 8'hA5);
        chk("t3_hold_md1", memdata1, 8'h77);
        tick();

        // 6: read+write together is a write; read data register untouched
        memread0 = 1'b1; memwrite0 = 1'b1; addr0 = 16'h0005; writedata0 = 8'h99;
        memdata_ram = 8'h5B;
        tick();
        chk("t6_c1_wr_ram", memwrite_ram, 1'b1);
        chk("t6_c1_rd_ram", memread_ram, 1'b0);
        chk("t6_c1_wdata", writedata, 8'h99);
        tick();
        chk("t6_c2_stall0", stall0, 1'b0);
        chk("t6_c2_md0", memdata0, 8'hA5);
        tick();
        idle_inputs();
        settle();
        chk("t6_hold_md0", memdata0, 8'hA5);
        tick();

        // 4: both request continuously for 20 cycles
        do_reset();
        memread0 = 1'b1; addr0 = 16'h0010;
        memread1 = 1'b1; addr1 = 16'h0020;
        run0 = 1; run1 = 1; max_run = 1; completions = 0;
        for (int k = 1; k <= 20; k++) begin
            logic g;
            logic in_complete;
            tick();
            g           = ((((k - 1) / 2) % 2) == 1);
            in_complete = ((k % 2) == 0);
            chk($sformatf("t4_k%0d_gnt", k), gnt_id, g);
            chk($sformatf("t4_k%0d_rd_ram", k), memread_ram, !in_complete);
            chk($sformatf("t4_k%0d_stall0", k), stall0, !(in_complete && !g));
            chk($sformatf("t4_k%0d_stall1", k), stall1, !(in_complete && g));
            if (!stall0 || !stall1) completions++;
            if (stall0) run0++; else run0 = 0;
            if (stall1) run1++; else run1 = 0;
            if (run0 > max_run) max_run = run0;
            if (run1 > max_run) max_run = run1;
        end
        chk("t4_completions", completions, 10);
        chk("t4_max_wait_le4", (max_run <= 4), 1'b1);
        idle_inputs();
        tick();
        tick();

        // 5: reset during ISSUE of a core0 write, request held across it
        do_reset();
        memwrite0 = 1'b1; addr0 = 16'h0004; writedata0 = 8'h11;
        tick();
        chk("t5_issue_wr_ram", memwrite_ram, 1'b1);
        #2;
        reset = 1'b0;
        settle();
        chk("t5_rst_strobes", {memread_ram, memwrite_ram, memread_gpio, memwrite_gpio}, 4'b0000);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_stall0", stall0, 1'b1);
        tick();
        reset = 1'b1;
        settle();
        chk("t5_c0_busy", busy, 1'b0);
        tick();
        chk("t5_c1_wr_ram", memwrite_ram, 1'b1);
        chk("t5_c1_addr", addr, 16'h0004);
        chk("t5_c1_wdata", writedata, 8'h11);
        chk("t5_c1_stall0", stall0, 1'b1);
        tick();
        chk("t5_c2_stall0", stall0, 1'b0);
        tick();
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
